// File: rtl/alu_exec_unit.sv
// Multi-cycle MIPS execute ALU: one-cycle logic/arith ops, iterative sll.
// Optional macro ALU_OVERFLOW_EN enables the signed overflow flag for add/sub.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_SLL = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_ovf;
  logic             w_go_shift;

  assign w_sum      = a + b;
  assign w_dif      = a - b;
  assign w_sh_nxt   = {r_sh[WIDTH-2:0], 1'b0};
  assign w_go_shift = (ALU_control == C_SLL) && (shamt != '0);

  // Single-cycle result, taken straight from the operands at the accept edge
  always_comb begin
    w_res = '0;
    case (ALU_control)
      C_ADD:   w_res = w_sum;
      C_SUB:   w_res = w_dif;
      C_AND:   w_res = a & b;
      C_OR:    w_res = a | b;
      C_NOR:   w_res = ~(a | b);
      C_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLL:   w_res = b;
      default: w_res = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic w_add_ovf;
  logic w_sub_ovf;
  assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                     (w_dif[WIDTH-1] != a[WIDTH-1]);
  assign w_ovf = ((ALU_control == C_ADD) && w_add_ovf) ||
                 ((ALU_control == C_SUB) && w_sub_ovf);
`else
  assign w_ovf = 1'b0;
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (w_go_shift) begin
              r_sh    <= b;
              r_cnt   <= shamt;
              r_state <= S_SHIFT;
            end else begin
              r_result <= w_res;
              r_zero   <= (w_res == '0);
              r_ovf    <= w_ovf;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_sh  <= w_sh_nxt;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_result <= w_sh_nxt;
            r_zero   <= (w_sh_nxt == '0);
            r_ovf    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops
// against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  ALU_control;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ALU_control(ALU_control), .a(a), .b(b), .shamt(shamt),
    .busy(busy), .done(done), .result(result),
    .zero(zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] x,
                                input logic [31:0] y, input logic [4:0] s,
                                output logic [31:0] r, output logic o);
    longint sx, sy, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    o = 1'b0;
    case (c)
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
      4'b1111: r = y << s;
      default: r = 32'd0;
    endcase
`ifdef ALU_OVERFLOW_EN
    if (c == 4'b0010 || c == 4'b0110) begin
      v = (c == 4'b0010) ? sx + sy : sx - sy;
      o = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    end
`endif
  endfunction

  // Run one op from IDLE; checks latency, outputs, one-cycle done pulse.
  task automatic do_op(input string tag, input logic [3:0] c,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s);
    logic [31:0] er;
    logic        eo;
    int          lat, elat;
    model(c, x, y, s, er, eo);
    elat = (c == 4'b1111 && s != 0) ? int'(s) + 1 : 1;
    ALU_control = c; a = x; b = y; shamt = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; shamt = 5'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " busy"}, 64'(busy), 64'd1);
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " zero"}, 64'(zero), 64'(er == 32'd0));
    check({tag, " ovf"}, 64'(overflow), 64'(eo));
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  logic [3:0] codes [14] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                             4'b1100, 4'b0111, 4'b1111, 4'b1111,
                             4'b0011, 4'b0100, 4'b0101, 4'b1000,
                             4'b1001, 4'b1110};

  initial begin
    logic [31:0] x, y;
    int ndone;
    reset = 1'b1; start = 1'b0; ALU_control = 4'b0;
    a = '0; b = '0; shamt = '0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst zero", 64'(zero), 64'd0);
    check("rst ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op("add", 4'b0010, 32'h5, 32'h3, 5'd0);
    do_op("sub0", 4'b0110, 32'h7, 32'h7, 5'd0);
    do_op("slt1", 4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0);
    do_op("slt0", 4'b0111, 32'h1, 32'hFFFFFFFF, 5'd0);
    do_op("and", 4'b0000, 32'hF0F0_1234, 32'hFF00_FF0F, 5'd0);
    do_op("or", 4'b0001, 32'hF0F0_1234, 32'h0F00_0001, 5'd0);
    do_op("nor", 4'b1100, 32'h0, 32'h0, 5'd0);
    do_op("sll31", 4'b1111, 32'h0, 32'h1, 5'd31);
    do_op("sll0", 4'b1111, 32'h0, 32'hDEAD_BEEF, 5'd0);
    do_op("sll1", 4'b1111, 32'h0, 32'h8000_0001, 5'd1);
    do_op("addovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
    do_op("subovf", 4'b0110, 32'h80000000, 32'h1, 5'd0);
    do_op("bad0011", 4'b0011, 32'h1234, 32'h5678, 5'd3);
    do_op("bad1010", 4'b1010, 32'hFFFF, 32'h1, 5'd3);

    // reset in the middle of a long shift
    ALU_control = 4'b1111; a = 32'h0; b = 32'h1; shamt = 5'd20;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    check("abort still idle", 64'(busy), 64'd0);

    // start held high: one done every other cycle
    ALU_control = 4'b0010; a = 32'd100; b = 32'd23; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("b2b done", 64'(done), 64'(k % 2));
    end
    start = 1'b0;
    check("b2b result", 64'(result), 64'd123);
    repeat (2) @(negedge clk);
    check("b2b idle", 64'(busy), 64'd0);

    // start during shift is ignored
    ALU_control = 4'b1111; a = 32'h0; b = 32'h3; shamt = 5'd10;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ALU_control = 4'b0010; a = 32'd5; b = 32'd3; shamt = 5'd0;
    repeat (5) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
      if (done) check("ign result", 64'(result), 64'h0C00);
    end
    check("ign ndone", 64'(ndone), 64'd1);
    check("ign idle", 64'(busy), 64'd0);

    // random ops against the model
    for (int i = 0; i < 150; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'h7FFFFFFF;
        1: y = 32'h80000000;
        2: y = x;
        default: ;
      endcase
      do_op("rand", codes[$urandom_range(0, 13)], x, y,
            5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle MIPS execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control unit and performs the selected operation on two operands. Single-cycle operations (add, sub, and, or, nor, slt) complete in one cycle. Shift-left-logical runs on an iterative one-bit-per-cycle shifter. A start/busy/done handshake lets the datapath sequencer stall while a shift is in progress.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- SHW, 5, shift-amount width; shifts up to 2^SHW−1

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- ALU_control  input  4  operation code: 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 0111 slt, 1111 sll
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt / immediate)
- shamt  input  SHW  shift amount (sll only)
- busy  output  1  high whenever the unit is not IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  registered result, held until the next accepted start
- zero  output  1  result == 0, registered with result
- overflow  output  1  signed overflow flag (see Configuration)

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE. All outputs reset to 0: busy, done, result, zero, overflow.
- IDLE, start=1: latch ALU_control, a, b, shamt.
  - Code 1111 with shamt≠0: load shift register with b, load a counter with shamt, go to SHIFT.
  - Any other case: compute the result into the result register, go to DONE.
- SHIFT: each cycle, shift register <<= 1 (zero fill) and counter −1. When the counter reaches 1, the final shifted value is written to result and the state goes to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- start while busy=1 is ignored; no queuing.
- Arithmetic rules:
  - Add and sub wrap modulo 2^WIDTH.
  - slt is signed two's-complement compare: result = {WIDTH−1 zeros, a<b}.
  - nor = ~(a|b).
  - sll with shamt=0 gives result = b.
- Unrecognised codes (including 1xxx other than 1100/1111, and 0011/0100/0101): result=0, zero=1, overflow=0, normal one-cycle completion.
- zero and overflow update only in the same cycle as result.
- reset asserted in any state aborts the operation: immediate return to IDLE, outputs cleared, no done pulse.

## Timing
- Start accepted at edge T.
  - Non-shift op: result/zero/overflow valid and done=1 in cycle T+1, busy=1 in T+1, IDLE at T+2.
  - sll with shamt=n≥1: SHIFT occupies cycles T+1..T+n, done in cycle T+n+1, IDLE at T+n+2.
- Maximum throughput: one non-shift op every 2 cycles. The earliest next start is accepted at the edge that ends the DONE cycle's IDLE successor, i.e. busy must be observed 0.
- ALU_control, a, b and shamt need only be stable at the accepting edge.

## Configuration
- ALU_OVERFLOW_EN defined: overflow computed for add and sub only.
  - Add: operands of equal sign, result sign different.
  - Sub: a and b of opposite sign, result sign ≠ a's sign.
  - overflow=0 for all other codes.
  - Result is still the wrapped value; no trap.
- ALU_OVERFLOW_EN undefined: the overflow port remains, tied to 0; no overflow logic is synthesised.

## Test plan
- Reset: reset=1 mid-SHIFT (sll, shamt=20, after 5 shift cycles) → busy=0, done never pulses, result=0 next cycle.
- Add: a=0x00000005, b=0x00000003, code 0010 → done at T+1, result=0x00000008, zero=0. Sub of 7−7 → result=0, zero=1.
- slt signed: a=0xFFFFFFFF, b=0x00000001, code 0111 → result=1. Swapped operands → result=0.
- sll: b=0x00000001, shamt=31, code 1111 → busy high 32 cycles, done at T+32, result=0x80000000. shamt=0 → done at T+1, result=b.
- Handshake: start held high continuously with back-to-back adds → one done every 2 cycles. A second start during SHIFT is ignored and its operands are unused.
- With ALU_OVERFLOW_EN: 0x7FFFFFFF+1 → result=0x80000000, overflow=1. Sub 0x80000000−1 → overflow=1. Without the macro, overflow=0 in both cases.
